// File: rtl/period_meter_pkg.sv
// Shared constants and FSM state encoding for the period meter and
// anything else that needs to interpret its counters.
package period_meter_pkg;

  localparam int CNT_W_DEFAULT       = 26;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // All-ones saturation value, sliced down to the counter width by the user.
  localparam logic [63:0] SAT_VALUE = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/period_meter_sync.sv
// Generic multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// system clock cycles, reporting once per detected rising edge.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] SAT = SAT_VALUE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             w_sync;
  logic             r_delay;
  logic             w_rise;
  logic             w_fall;
  state_e           r_state;
  state_e           w_stateNext;
  logic             w_start;
  logic             w_report;
  logic             w_clear;
  logic             w_count;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hiCnt;
  logic [CNT_W-1:0] w_cntInc;
  logic [CNT_W-1:0] w_hiInc;
  logic             r_sat;
  logic             r_fallSeen;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .i_d  (sig_in),
    .o_q  (w_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_delay <= 1'b0;
    end else begin
      r_delay <= w_sync;
    end
  end

  assign w_rise = w_sync & ~r_delay;
  assign w_fall = ~w_sync & r_delay;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Dropping enable wins over a coincident rise, so no half-finished report.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_report    = 1'b0;
    w_clear     = 1'b0;
    w_count     = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_stateNext = ST_ARM;
        end
      end
      ST_ARM: begin
        busy = 1'b1;
        if (!enable) begin
          w_stateNext = ST_IDLE;
          w_clear     = 1'b1;
        end else if (w_rise) begin
          w_stateNext = ST_MEASURE;
          w_start     = 1'b1;
        end
      end
      ST_MEASURE: begin
        busy = 1'b1;
        if (!enable) begin
          w_stateNext = ST_IDLE;
          w_clear     = 1'b1;
        end else if (w_rise) begin
          w_report = 1'b1;
          w_start  = 1'b1;
        end else begin
          w_count = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign w_cntInc = (r_cnt == SAT) ? SAT : r_cnt + ONE;
  assign w_hiInc  = (r_hiCnt == SAT) ? SAT : r_hiCnt + ONE;

  // Counters restart at 1 so that the rise cycle itself is part of the period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_hiCnt    <= '0;
      r_sat      <= 1'b0;
      r_fallSeen <= 1'b0;
    end else if (w_clear) begin
      r_cnt      <= '0;
      r_hiCnt    <= '0;
      r_sat      <= 1'b0;
      r_fallSeen <= 1'b0;
    end else if (w_start) begin
      r_cnt      <= ONE;
      r_hiCnt    <= ONE;
      r_sat      <= 1'b0;
      r_fallSeen <= 1'b0;
    end else if (w_count) begin
      r_cnt <= w_cntInc;
      r_sat <= r_sat | (w_cntInc == SAT);
      if (w_sync && !r_fallSeen) begin
        r_hiCnt <= w_hiInc;
      end
      if (w_fall) begin
        r_fallSeen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period       <= '0;
      high_time    <= '0;
      overflow     <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= w_report;
      if (w_report) begin
        period    <= r_cnt;
        high_time <= r_hiCnt;
        overflow  <= r_sat;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: a wide instance and a 4-bit
// saturating instance run side by side against a time-stamp based model.
module tb_period_meter;

  localparam int CW_A   = 26;
  localparam int CW_B   = 4;
  localparam int SYNC_A = 2;
  localparam int SYNC_B = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enA = 1'b0, sigA = 1'b0, enB = 1'b0, sigB = 1'b0;
  logic [CW_A-1:0] perA, hiA;
  logic            pvA, ovA, busyA;
  logic [CW_B-1:0] perB, hiB;
  logic            pvB, ovB, busyB;

  period_meter #(.CNT_W(CW_A), .SYNC_STAGES(SYNC_A)) dutA (
    .clock(clock), .reset(reset), .enable(enA), .sig_in(sigA),
    .period(perA), .high_time(hiA), .period_valid(pvA),
    .overflow(ovA), .busy(busyA)
  );

  period_meter #(.CNT_W(CW_B), .SYNC_STAGES(SYNC_B)) dutB (
    .clock(clock), .reset(reset), .enable(enB), .sig_in(sigB),
    .period(perB), .high_time(hiB), .period_valid(pvB),
    .overflow(ovB), .busy(busyB)
  );

  always #5 clock = ~clock;

  int     compared = 0;
  int     mismatched = 0;
  longint edgeN = 0;

  // Square-wave generators, one per instance
  bit genOn[2];
  int genPer[2], genHigh[2], genPhase[2];

  // Reference model: rises and falls are time-stamped in edge numbers and
  // the reported values are differences of those stamps, clipped at max.
  bit     mBusy[2], mPv[2], mOvf[2];
  longint mPer[2], mHi[2], mTRise[2], mTFall[2], mMax[2];
  int     mStages[2];
  bit     mPipe[2][5];

  int pulsesA = 0, pulsesB = 0, sampRiseA = 0;
  bit prevSampA = 1'b0, lastSampA = 1'b0;

  typedef struct {
    int    unit;
    int    per;
    int    high;
    int    cycles;
    int    expPer;
    int    expHi;
    bit    expOvf;
    string name;
  } seg_t;

  seg_t segs[6];

  function automatic longint minL(longint a, longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  task automatic recordCompare(bit ok, string name, string detail);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s: %s", name, detail);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mBusy[k]  = 1'b0;
      mPv[k]    = 1'b0;
      mOvf[k]   = 1'b0;
      mPer[k]   = 0;
      mHi[k]    = 0;
      mTRise[k] = -1;
      mTFall[k] = -1;
      for (int i = 0; i < 5; i++) mPipe[k][i] = 1'b0;
    end
  endtask

  task automatic modelEdge(int k, bit en, bit sig);
    int     s;
    bit     sNow, sDel, rise, fall;
    longint d;
    s    = mStages[k];
    sNow = mPipe[k][s-1];
    sDel = mPipe[k][s];
    rise = sNow & !sDel;
    fall = !sNow & sDel;
    mPv[k] = 1'b0;
    if (!mBusy[k]) begin
      if (en) begin
        mBusy[k]  = 1'b1;
        mTRise[k] = -1;
      end
    end else if (!en) begin
      mBusy[k]  = 1'b0;
      mTRise[k] = -1;
    end else if (rise) begin
      if (mTRise[k] >= 0) begin
        d       = edgeN - mTRise[k];
        mPer[k] = minL(d, mMax[k]);
        mHi[k]  = minL(((mTFall[k] >= 0) ? mTFall[k] : edgeN) - mTRise[k], mMax[k]);
        mOvf[k] = (d >= mMax[k]);
        mPv[k]  = 1'b1;
      end
      mTRise[k] = edgeN;
      mTFall[k] = -1;
    end else if (fall && mTRise[k] >= 0 && mTFall[k] < 0) begin
      mTFall[k] = edgeN;
    end
    for (int i = s; i > 0; i--) mPipe[k][i] = mPipe[k][i-1];
    mPipe[k][0] = sig;
  endtask

  task automatic checkOutput();
    bit okA, okB;
    okA = (pvA === mPv[0]) && (perA === CW_A'(mPer[0])) && (hiA === CW_A'(mHi[0]))
          && (ovA === mOvf[0]) && (busyA === mBusy[0]);
    recordCompare(okA, "cycle_A", $sformatf(
      "edge %0d got pv=%0b period=%0d high=%0d ovf=%0b busy=%0b, want pv=%0b period=%0d high=%0d ovf=%0b busy=%0b",
      edgeN, pvA, perA, hiA, ovA, busyA, mPv[0], mPer[0], mHi[0], mOvf[0], mBusy[0]));
    okB = (pvB === mPv[1]) && (perB === CW_B'(mPer[1])) && (hiB === CW_B'(mHi[1]))
          && (ovB === mOvf[1]) && (busyB === mBusy[1]);
    recordCompare(okB, "cycle_B", $sformatf(
      "edge %0d got pv=%0b period=%0d high=%0d ovf=%0b busy=%0b, want pv=%0b period=%0d high=%0d ovf=%0b busy=%0b",
      edgeN, pvB, perB, hiB, ovB, busyB, mPv[1], mPer[1], mHi[1], mOvf[1], mBusy[1]));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, check at negedge
  task automatic applyStimulus();
    logic eA, sA, eB, sB;
    if (genOn[0]) begin
      sigA = (genPhase[0] < genHigh[0]);
      genPhase[0] = (genPhase[0] + 1 >= genPer[0]) ? 0 : genPhase[0] + 1;
    end
    if (genOn[1]) begin
      sigB = (genPhase[1] < genHigh[1]);
      genPhase[1] = (genPhase[1] + 1 >= genPer[1]) ? 0 : genPhase[1] + 1;
    end
    eA = enA; sA = sigA; eB = enB; sB = sigB;
    @(posedge clock);
    edgeN++;
    if (!reset) begin
      modelEdge(0, eA, sA);
      modelEdge(1, eB, sB);
      if (sA && !prevSampA) sampRiseA++;
      prevSampA = sA;
    end
    lastSampA = sA;
    @(negedge clock);
    checkOutput();
    if (pvA) pulsesA++;
    if (pvB) pulsesB++;
    if (mismatched > 50) begin
      $display("[TB] too many errors, stopping early");
      printSummary();
      $finish;
    end
  endtask

  task automatic waitPulse(int unit, int maxTicks, output int ticks, output bit seen);
    ticks = 0;
    seen  = 1'b0;
    while (!seen && ticks < maxTicks) begin
      applyStimulus();
      ticks++;
      seen = (unit == 0) ? pvA : pvB;
    end
  endtask

  initial begin : main
    int ticks, lat;
    bit seen;
    int snap;
    int k, p, h, cyc, dropAt, dropLen;
    bit doDrop, en;

    mMax[0] = (64'd1 << CW_A) - 1;
    mMax[1] = (64'd1 << CW_B) - 1;
    mStages[0] = SYNC_A;
    mStages[1] = SYNC_B;
    modelReset();

    segs[0] = '{0, 10,    4,    60,    10,    4,    1'b0, "seg_p10_h4"};
    segs[1] = '{0, 6,     1,    40,    6,     1,    1'b0, "seg_p6_glitch"};
    segs[2] = '{1, 20,    10,   100,   15,    10,   1'b1, "seg_sat_p20"};
    segs[3] = '{1, 8,     3,    50,    8,     3,    1'b0, "seg_recover_p8"};
    segs[4] = '{1, 200,   100,  450,   15,    15,   1'b1, "seg_sat_high"};
    segs[5] = '{0, 10002, 5001, 30020, 10002, 5001, 1'b0, "seg_divider"};

    $display("[TB] reset");
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    recordCompare(perA == 0 && hiA == 0 && !pvA && !ovA && !busyA, "reset_state_A",
      $sformatf("got period=%0d high=%0d pv=%0b ovf=%0b busy=%0b, want all 0", perA, hiA, pvA, ovA, busyA));
    recordCompare(perB == 0 && hiB == 0 && !pvB && !ovB && !busyB, "reset_state_B",
      $sformatf("got period=%0d high=%0d pv=%0b ovf=%0b busy=%0b, want all 0", perB, hiB, pvB, ovB, busyB));
    reset = 1'b0;
    enA = 1'b1;
    enB = 1'b1;
    genOn[0] = 1'b1; genPer[0] = 10; genHigh[0] = 4;  genPhase[0] = 0;
    genOn[1] = 1'b1; genPer[1] = 20; genHigh[1] = 10; genPhase[1] = 0;
    applyStimulus();
    recordCompare(busyA && !pvA, "arm_after_reset",
      $sformatf("got busy=%0b pv=%0b, want busy=1 pv=0", busyA, pvA));

    $display("[TB] table segments");
    for (int i = 0; i < 6; i++) begin
      genPer[segs[i].unit]   = segs[i].per;
      genHigh[segs[i].unit]  = segs[i].high;
      genPhase[segs[i].unit] = 0;
      snap = (segs[i].unit == 0) ? pulsesA : pulsesB;
      repeat (segs[i].cycles) applyStimulus();
      if (segs[i].unit == 0) begin
        recordCompare(perA == segs[i].expPer && hiA == segs[i].expHi && ovA == segs[i].expOvf,
          segs[i].name, $sformatf("got period=%0d high=%0d ovf=%0b, want %0d/%0d/%0b",
          perA, hiA, ovA, segs[i].expPer, segs[i].expHi, segs[i].expOvf));
        recordCompare(pulsesA > snap, {segs[i].name, "_pulses"},
          $sformatf("got %0d pulses, want at least 1", pulsesA - snap));
      end else begin
        recordCompare(perB == segs[i].expPer && hiB == segs[i].expHi && ovB == segs[i].expOvf,
          segs[i].name, $sformatf("got period=%0d high=%0d ovf=%0b, want %0d/%0d/%0b",
          perB, hiB, ovB, segs[i].expPer, segs[i].expHi, segs[i].expOvf));
        recordCompare(pulsesB > snap, {segs[i].name, "_pulses"},
          $sformatf("got %0d pulses, want at least 1", pulsesB - snap));
      end
    end

    $display("[TB] enable drop before a rise");
    genPer[0] = 10; genHigh[0] = 4; genPhase[0] = 0;
    waitPulse(0, 40, ticks, seen);
    recordCompare(seen, "steady_first_pulse", $sformatf("got none in %0d cycles, want a pulse", ticks));
    waitPulse(0, 40, ticks, seen);
    recordCompare(seen && ticks == 10, "pulse_spacing",
      $sformatf("got spacing %0d (seen=%0b), want 10", ticks, seen));
    recordCompare(perA == 10 && hiA == 4 && !ovA, "steady_10_4",
      $sformatf("got period=%0d high=%0d ovf=%0b, want 10/4/0", perA, hiA, ovA));
    repeat (6) applyStimulus();
    enA = 1'b0;
    repeat (5) applyStimulus();
    recordCompare(perA == 10 && hiA == 4 && !busyA, "held_while_disabled",
      $sformatf("got period=%0d high=%0d busy=%0b, want 10/4/0", perA, hiA, busyA));
    enA = 1'b1;
    waitPulse(0, 60, ticks, seen);
    recordCompare(seen && (11 + ticks) == 30, "rearm_two_rises",
      $sformatf("got pulse %0d cycles after previous (seen=%0b), want 30", 11 + ticks, seen));
    recordCompare(perA == 10 && hiA == 4, "rearm_values",
      $sformatf("got period=%0d high=%0d, want 10/4", perA, hiA));

    $display("[TB] reset mid-period");
    repeat (4) applyStimulus();
    reset = 1'b1;
    #1;
    recordCompare(perA == 0 && hiA == 0 && !pvA && !ovA && !busyA, "reset_immediate_A",
      $sformatf("got period=%0d high=%0d pv=%0b ovf=%0b busy=%0b, want all 0", perA, hiA, pvA, ovA, busyA));
    recordCompare(perB == 0 && hiB == 0 && !pvB && !ovB && !busyB, "reset_immediate_B",
      $sformatf("got period=%0d high=%0d pv=%0b ovf=%0b busy=%0b, want all 0", perB, hiB, pvB, ovB, busyB));
    modelReset();
    prevSampA = 1'b0;
    sampRiseA = 0;
    repeat (3) applyStimulus();
    reset = 1'b0;
    waitPulse(0, 60, ticks, seen);
    recordCompare(seen && sampRiseA == 2, "post_reset_second_rise",
      $sformatf("got pulse after %0d sampled rises (seen=%0b), want 2", sampRiseA, seen));

    $display("[TB] latency");
    genPer[0] = 6; genHigh[0] = 1; genPhase[0] = 0;
    repeat (20) applyStimulus();
    ticks = 0;
    do begin
      applyStimulus();
      ticks++;
    end while (!lastSampA && ticks < 10);
    lat = 1;
    while (!pvA && lat < 20) begin
      applyStimulus();
      lat++;
    end
    recordCompare(pvA && lat == SYNC_A + 1, "latency",
      $sformatf("got pulse on edge %0d (pv=%0b), want edge %0d", lat, pvA, SYNC_A + 1));
    recordCompare(perA == 6 && hiA == 1, "glitch_values",
      $sformatf("got period=%0d high=%0d, want 6/1", perA, hiA));

    $display("[TB] constant input");
    genPer[1] = 8; genHigh[1] = 3; genPhase[1] = 0;
    repeat (30) applyStimulus();
    genOn[1] = 1'b0;
    sigB = 1'b1;
    repeat (10) applyStimulus();
    snap = pulsesB;
    repeat (70) applyStimulus();
    recordCompare(pulsesB == snap, "const_high_no_pulse",
      $sformatf("got %0d pulses, want 0", pulsesB - snap));
    sigB = 1'b0;
    repeat (5) applyStimulus();
    sigB = 1'b1;
    repeat (10) applyStimulus();
    recordCompare(perB == 15 && hiB == 15 && ovB, "const_high_overflow",
      $sformatf("got period=%0d high=%0d ovf=%0b, want 15/15/1", perB, hiB, ovB));

    $display("[TB] random");
    genOn[1] = 1'b1;
    enB = 1'b1;
    for (int it = 0; it < 40; it++) begin
      k       = $urandom_range(0, 1);
      p       = (k == 0) ? $urandom_range(2, 40) : $urandom_range(2, 30);
      h       = $urandom_range(1, p - 1);
      cyc     = $urandom_range(40, 160);
      doDrop  = ($urandom_range(0, 2) == 0);
      dropAt  = $urandom_range(0, cyc - 1);
      dropLen = $urandom_range(1, 15);
      genPer[k]  = p;
      genHigh[k] = h;
      for (int c = 0; c < cyc; c++) begin
        en = doDrop ? !(c >= dropAt && c < dropAt + dropLen) : 1'b1;
        if (k == 0) enA = en;
        else        enB = en;
        applyStimulus();
      end
      enA = 1'b1;
      enB = 1'b1;
    end

    printSummary();
    $finish;
  end

endmodule
